// File: rtl/pairing_host_sequencer.sv
// Host-side sequencer for the pairing core: loads operands into every operand bank,
// pulses run, waits for completion, then reads back and resolves redundant-limb results.
module pairing_host_sequencer #(
  parameter int LIMB_W     = 64,
  parameter int N_LIMB     = 5,
  parameter int CARRY_W    = 3,
  parameter int N_BANK     = 4,
  parameter int BANK_SHIFT = 7,
  parameter int ADDR_W     = 9,
  parameter int RD_LAT     = 2,
  parameter int BUSY_TO    = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cmd_start,
  input  logic [3:0]                            cmd_func,
  input  logic [ADDR_W-1:0]                     cmd_rd_base,
  input  logic [ADDR_W-1:0]                     cmd_rd_cnt,
  input  logic                                  ld_valid,
  output logic                                  ld_ready,
  input  logic [ADDR_W-1:0]                     ld_addr,
  input  logic [LIMB_W*N_LIMB-1:0]              ld_data,
  input  logic                                  ld_last,
  output logic                                  core_swrst,
  output logic                                  core_run,
  output logic [3:0]                            core_n_func,
  input  logic                                  core_busy,
  output logic                                  core_in_en,
  output logic [ADDR_W-1:0]                     core_in_addr,
  output logic [N_LIMB*(LIMB_W+CARRY_W)-1:0]    core_in_data,
  output logic [ADDR_W-1:0]                     core_out_addr,
  input  logic [N_LIMB*(LIMB_W+CARRY_W)-1:0]    core_out_data,
  output logic                                  res_valid,
  input  logic                                  res_ready,
  output logic [LIMB_W*N_LIMB+CARRY_W-1:0]      res_data,
  output logic                                  res_last,
  output logic                                  done,
  output logic                                  err_timeout
);

  localparam int DATA_W = LIMB_W * N_LIMB;
  localparam int LW     = LIMB_W + CARRY_W;
  localparam int OUT_W  = N_LIMB * LW;
  localparam int RES_W  = DATA_W + CARRY_W;
  localparam int BNK_W  = (N_BANK > 1) ? $clog2(N_BANK) : 1;
  localparam int LMB_W  = (N_LIMB > 1) ? $clog2(N_LIMB) : 1;
  localparam int LAT_W  = $clog2(RD_LAT + 1);
  localparam int TMR_W  = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_HI, S_WAIT_LO, S_RD, S_CONV, S_OUT
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          func_q, func_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   k_q, k_d;
  logic [ADDR_W-1:0]   oaddr_q, oaddr_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                last_q, last_d;
  logic [BNK_W-1:0]    bank_q, bank_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [LMB_W-1:0]    limb_q, limb_d;
  logic [OUT_W-1:0]    cap_q, cap_d;
  logic [RES_W-1:0]    acc_q, acc_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                ld_fire, bank_wr, cur_last;
  logic [ADDR_W-1:0]   wsel_addr, bank_off;
  logic [DATA_W-1:0]   wsel_data;
  logic [LW-1:0]       limb_raw;
  logic [RES_W-1:0]    limb_ext;

  // Bank 0 is written in the accept cycle straight from the bus; later banks replay the held word.
  assign ld_ready  = (state_q == S_LOAD) && (bank_q == '0);
  assign ld_fire   = ld_ready && ld_valid;
  assign bank_wr   = ld_fire || ((state_q == S_LOAD) && (bank_q != '0));
  assign wsel_addr = (bank_q == '0) ? ld_addr : waddr_q;
  assign wsel_data = (bank_q == '0) ? ld_data : wdata_q;
  assign cur_last  = (bank_q == '0) ? ld_last : last_q;
  assign bank_off  = ADDR_W'(bank_q) << BANK_SHIFT;

  assign core_in_en   = bank_wr;
  assign core_in_addr = bank_wr ? (wsel_addr + bank_off) : '0;

  always_comb begin
    core_in_data = '0;
    if (bank_wr) begin
      for (int i = 0; i < N_LIMB; i++)
        core_in_data[i*LW +: LW] = {{CARRY_W{1'b0}}, wsel_data[i*LIMB_W +: LIMB_W]};
    end
  end

  // Limbs are folded most-significant first (Horner), so no variable shifter is needed.
  assign limb_raw = cap_q[OUT_W-1 -: LW];
  assign limb_ext = {{(RES_W-LW){limb_raw[LW-1]}}, limb_raw};

  assign core_swrst    = (state_q == S_LOAD);
  assign core_run      = (state_q == S_START);
  assign core_n_func   = func_q;
  assign core_out_addr = oaddr_q;
  assign res_valid     = (state_q == S_OUT);
  assign res_data      = acc_q;
  assign res_last      = (state_q == S_OUT) && (k_q == cnt_q - ADDR_W'(1));
  assign done          = done_q;
  assign err_timeout   = err_q;

  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    oaddr_d = oaddr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    bank_d  = bank_q;
    tmr_d   = tmr_q;
    lat_d   = lat_q;
    limb_d  = limb_q;
    cap_d   = cap_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          state_d = S_LOAD;
          func_d  = cmd_func;
          base_d  = cmd_rd_base;
          cnt_d   = cmd_rd_cnt;
          err_d   = 1'b0;
          bank_d  = '0;
        end
      end
      S_LOAD: begin
        if (bank_wr) begin
          if (ld_fire) begin
            waddr_d = ld_addr;
            wdata_d = ld_data;
            last_d  = ld_last;
          end
          if (bank_q == BNK_W'(N_BANK-1)) begin
            bank_d = '0;
            if (cur_last) state_d = S_START;
          end else begin
            bank_d = bank_q + BNK_W'(1);
          end
        end
      end
      S_START: begin
        state_d = S_WAIT_HI;
        tmr_d   = '0;
      end
      S_WAIT_HI: begin
        if (core_busy) begin
          state_d = S_WAIT_LO;
        end else if (tmr_q == TMR_W'(BUSY_TO-1)) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_WAIT_LO: begin
        if (!core_busy) begin
          k_d = '0;
          if (cnt_q == '0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_RD;
            oaddr_d = base_q;
            lat_d   = '0;
          end
        end
      end
      S_RD: begin
        if (lat_q == LAT_W'(RD_LAT)) begin
          cap_d   = core_out_data;
          acc_d   = '0;
          limb_d  = '0;
          state_d = S_CONV;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_CONV: begin
        cap_d = cap_q << LW;
        acc_d = (acc_q << LIMB_W) + limb_ext;
        if (limb_q == LMB_W'(N_LIMB-1)) state_d = S_OUT;
        else                            limb_d  = limb_q + LMB_W'(1);
      end
      S_OUT: begin
        if (res_ready) begin
          k_d = k_q + ADDR_W'(1);
          if (k_d == cnt_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_RD;
            oaddr_d = base_q + k_d;
            lat_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      func_q  <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      oaddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
      bank_q  <= '0;
      tmr_q   <= '0;
      lat_q   <= '0;
      limb_q  <= '0;
      cap_q   <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      oaddr_q <= oaddr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      bank_q  <= bank_d;
      tmr_q   <= tmr_d;
      lat_q   <= lat_d;
      limb_q  <= limb_d;
      cap_q   <= cap_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_pairing_host_sequencer.sv
// Bench for pairing_host_sequencer: core model with busy/readback, table vectors, random sessions.
module tb_pairing_host_sequencer;
  localparam int LIMB_W = 64, N_LIMB = 5, CARRY_W = 3, N_BANK = 4;
  localparam int BANK_SHIFT = 7, ADDR_W = 9, RD_LAT = 2, BUSY_TO = 1024;
  localparam int DATA_W = LIMB_W*N_LIMB, LW = LIMB_W+CARRY_W, OW = N_LIMB*LW, TW = DATA_W+CARRY_W;
  localparam int NADDR = 1 << ADDR_W;

  logic clk = 1'b0, rst = 1'b0;
  logic cmd_start = 0; logic [3:0] cmd_func = 0;
  logic [ADDR_W-1:0] cmd_rd_base = 0, cmd_rd_cnt = 0;
  logic ld_valid = 0, ld_ready, ld_last = 0;
  logic [ADDR_W-1:0] ld_addr = 0;
  logic [DATA_W-1:0] ld_data = 0;
  logic core_swrst, core_run, core_busy, core_in_en, res_valid, res_ready, res_last, done, err_timeout;
  logic [3:0] core_n_func;
  logic [ADDR_W-1:0] core_in_addr, core_out_addr;
  logic [OW-1:0] core_in_data, core_out_data;
  logic [TW-1:0] res_data;

  always #5 clk = ~clk;

  pairing_host_sequencer #(.LIMB_W(LIMB_W), .N_LIMB(N_LIMB), .CARRY_W(CARRY_W), .N_BANK(N_BANK),
    .BANK_SHIFT(BANK_SHIFT), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .BUSY_TO(BUSY_TO)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_func(cmd_func), .cmd_rd_base(cmd_rd_base),
    .cmd_rd_cnt(cmd_rd_cnt), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_last(ld_last), .core_swrst(core_swrst), .core_run(core_run),
    .core_n_func(core_n_func), .core_busy(core_busy), .core_in_en(core_in_en),
    .core_in_addr(core_in_addr), .core_in_data(core_in_data), .core_out_addr(core_out_addr),
    .core_out_data(core_out_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_last(res_last), .done(done), .err_timeout(err_timeout));

  int errors = 0, checks = 0;
  function automatic void chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  // ---------------- core model ----------------
  int ph = 0, busy_dly = 2, busy_len = 5;
  bit busy_never = 0;
  always @(posedge clk or posedge rst)
    if (rst) ph <= 0;
    else if (core_run && !busy_never) ph <= 1;
    else if (ph != 0) ph <= (ph >= busy_dly + busy_len) ? 0 : ph + 1;
  assign core_busy = (ph > busy_dly);

  logic [OW-1:0] rd_mem [NADDR];
  logic [ADDR_W-1:0] ap [RD_LAT];
  always @(posedge clk) begin
    ap[0] <= core_out_addr;
    for (int i = 1; i < RD_LAT; i++) ap[i] <= ap[i-1];
  end
  assign core_out_data = rd_mem[ap[RD_LAT-1]];

  // ---------------- monitors ----------------
  typedef struct packed { logic [ADDR_W-1:0] a; logic [OW-1:0] d; } wr_t;
  wr_t wr_q[$];
  logic [TW-1:0] res_q[$];
  bit last_q[$];
  logic [ADDR_W-1:0] raddr_q[$];
  int cyc = 0, run_cnt = 0, done_cnt = 0, pend = 0, rdy_viol = 0, done_cyc = 0, fall_cyc = 0;
  logic [3:0] run_func = 0;
  logic busy_prev = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    busy_prev <= core_busy;
    if (rst) pend <= 0;
    else begin
      if (core_in_en) wr_q.push_back({core_in_addr, core_in_data});
      if (pend > 0 && ld_ready) rdy_viol <= rdy_viol + 1;
      if (ld_valid && ld_ready) pend <= N_BANK - 1;
      else if (core_in_en && pend > 0) pend <= pend - 1;
      if (core_run) begin run_cnt <= run_cnt + 1; run_func <= core_n_func; end
      if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
      if (busy_prev && !core_busy) fall_cyc <= cyc;
      if (res_valid && res_ready) begin
        res_q.push_back(res_data); last_q.push_back(res_last); raddr_q.push_back(core_out_addr);
      end
    end
  end

  // ---------------- result-side driver (random ready, optional long stall) ----------------
  bit rr_rand = 0, stable = 0;
  int stall_at = 0, stall_req_n = 0, stall_ack_n = 0;
  logic [TW-1:0] hold_data;
  logic [ADDR_W-1:0] hold_addr;
  logic hold_last;
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_req_n != stall_ack_n && res_valid && res_q.size() == stall_at) begin
        res_ready = 1'b0;
        hold_data = res_data; hold_addr = core_out_addr; hold_last = res_last; stable = 1;
        repeat (50) begin
          @(negedge clk);
          if (!res_valid || res_data !== hold_data || core_out_addr !== hold_addr || res_last !== hold_last)
            stable = 0;
        end
        stall_ack_n = stall_req_n;
      end
      res_ready = rr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [OW-1:0] exp_in(input logic [DATA_W-1:0] d);
    logic [OW-1:0] r;
    r = '0;
    for (int i = 0; i < N_LIMB; i++) r[i*LW +: LIMB_W] = d[i*LIMB_W +: LIMB_W];
    return r;
  endfunction

  // value bits concatenate directly; each signed carry is worth 2^(LIMB_W*(i+1))
  function automatic logic [TW-1:0] resolve(input logic [OW-1:0] w);
    logic [TW-1:0] v;
    logic [CARRY_W-1:0] c;
    v = '0;
    for (int i = 0; i < N_LIMB; i++) v[i*LIMB_W +: LIMB_W] = w[i*LW +: LIMB_W];
    for (int i = 0; i < N_LIMB; i++) begin
      c = w[i*LW+LIMB_W +: CARRY_W];
      v = v + ({{(TW-CARRY_W){c[CARRY_W-1]}}, c} << (LIMB_W*(i+1)));
    end
    return v;
  endfunction

  function automatic logic [OW-1:0] mk(input logic [N_LIMB*CARRY_W-1:0] c, input logic [DATA_W-1:0] v);
    logic [OW-1:0] w;
    for (int i = 0; i < N_LIMB; i++) w[i*LW +: LW] = {c[i*CARRY_W +: CARRY_W], v[i*LIMB_W +: LIMB_W]};
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic bit outs_zero();
    return ({ld_ready, core_swrst, core_run, core_n_func, core_in_en, core_in_addr, core_in_data,
             core_out_addr, res_valid, res_data, res_last, done, err_timeout} == '0);
  endfunction

  // ---------------- stimulus tasks ----------------
  logic [ADDR_W-1:0] ld_a [64];
  logic [DATA_W-1:0] ld_d [64];

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic start_cmd(input logic [3:0] f, input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] c);
    cmd_func = f; cmd_rd_base = b; cmd_rd_cnt = c; cmd_start = 1; tick(); cmd_start = 0;
  endtask

  task automatic load_words(input int n, input int gapmax);
    bit acc;
    for (int w = 0; w < n; w++) begin
      if (gapmax > 0) repeat ($urandom_range(0, gapmax)) tick();
      ld_valid = 1; ld_addr = ld_a[w]; ld_data = ld_d[w]; ld_last = (w == n-1);
      acc = 0;
      for (int t = 0; t < 40; t++) begin @(negedge clk); if (ld_ready) begin acc = 1; break; end end
      @(posedge clk); #1; ld_valid = 0; ld_last = 0;
      if (!acc) begin chk("ld_accept", 0, 1); return; end
    end
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 0;
    for (int t = 0; t < budget; t++) begin @(negedge clk); if (done) begin seen = 1; break; end end
    chk(name, seen, 1);
    @(negedge clk);
  endtask

  task automatic session(input logic [3:0] f, input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] c,
                         input int nw, input int gap, input string tag);
    int r0, d0, idx, bad_w, bad_l, bad_a;
    wr_q.delete(); res_q.delete(); last_q.delete(); raddr_q.delete();
    r0 = run_cnt; d0 = done_cnt;
    start_cmd(f, b, c);
    @(negedge clk); chk({tag, " swrst"}, core_swrst, 1); tick();
    load_words(nw, gap);
    wait_done(4000 + int'(c)*200, {tag, " done"});
    chk({tag, " nwr"}, wr_q.size(), nw*N_BANK);
    bad_w = 0; idx = 0;
    for (int w = 0; w < nw; w++)
      for (int k = 0; k < N_BANK; k++) begin
        if (idx < wr_q.size() && (wr_q[idx].a !== ADDR_W'((int'(ld_a[w]) + k*(1<<BANK_SHIFT)) % NADDR) ||
                                  wr_q[idx].d !== exp_in(ld_d[w]))) bad_w++;
        idx++;
      end
    chk({tag, " wr content"}, bad_w, 0);
    chk({tag, " runs"}, run_cnt - r0, 1);
    chk({tag, " dones"}, done_cnt - d0, 1);
    chk({tag, " func"}, run_func, f);
    chk({tag, " nres"}, res_q.size(), c);
    bad_l = 0; bad_a = 0;
    for (int k = 0; k < res_q.size() && k < int'(c); k++) begin
      chk($sformatf("%s res%0d", tag, k), res_q[k], resolve(rd_mem[(int'(b)+k) % NADDR]));
      if (last_q[k] != (k == int'(c)-1)) bad_l++;
      if (raddr_q[k] !== ADDR_W'((int'(b)+k) % NADDR)) bad_a++;
    end
    if (c != 0) begin
      chk({tag, " last"}, bad_l, 0);
      chk({tag, " raddr"}, bad_a, 0);
    end
    chk({tag, " err"}, err_timeout, 0);
    @(posedge clk); #1;
  endtask

  typedef struct { logic [OW-1:0] din; logic [TW-1:0] exp; } vec_t;
  vec_t tbl [12];

  initial begin
    int v0, rc, dc, r0, d0;
    bit seen, early;
    logic [TW-1:0] one;
    one = 1;
    for (int i = 0; i < NADDR; i++) rd_mem[i] = '0;

    tbl[0]  = '{mk(15'd7, DATA_W'(1) << 64), '0};
    tbl[1]  = '{mk(15'd0, '0), '0};
    tbl[2]  = '{mk(15'd0, DATA_W'(5)), TW'(5)};
    tbl[3]  = '{mk(15'd1, '0), one << 64};
    tbl[4]  = '{mk(15'd7 << 12, '0), TW'(7) << 320};
    tbl[5]  = '{mk(15'd3 << 12, '0), TW'(3) << 320};
    tbl[6]  = '{mk(15'd4, DATA_W'(64'hFFFF_FFFF_FFFF_FFFF)), ~(TW'(3) << 64)};
    tbl[7]  = '{mk(15'd0, DATA_W'(64'hFFFF_FFFF_FFFF_FFFF) << 128), TW'(64'hFFFF_FFFF_FFFF_FFFF) << 128};
    tbl[8]  = '{mk(15'd7 << 3, DATA_W'(1) << 128), '0};
    tbl[9]  = '{mk(15'd0, ~DATA_W'(0)), (one << 320) - one};
    tbl[10] = '{mk(15'd7, '0), ~((one << 64) - one)};
    tbl[11] = '{mk((15'd1 << 6) | (15'd7 << 9), '0), ~((one << 256) - one) | (one << 192)};

    #3 rst = 1; #1;
    chk("reset outs", outs_zero(), 1);
    tick(); tick(); rst = 0; tick();

    // single word, no readback
    ld_a[0] = 9'h000;
    ld_d[0] = 320'h5b613c9ea7d20f48_91e62b7cd4508a3f_c29d6e0714b5f83a_7e1c09d4a6b235f8_d03a8c51e79f466d;
    session(4'h5, 9'h000, 9'd0, 1, 0, "t1");
    for (int k = 0; k < N_BANK && k < wr_q.size(); k++)
      chk($sformatf("t1 addr%0d", k), wr_q[k].a, ADDR_W'(k * 'h80));
    chk("t1 done after busy fall", done_cyc > fall_cyc, 1);

    // 28 words with gaps; ld_ready must stay low during bank replay
    v0 = rdy_viol;
    for (int w = 0; w < 28; w++) begin ld_a[w] = ADDR_W'(w*3 + 100); ld_d[w] = rnd_data(); end
    session(4'h2, 9'h000, 9'd0, 28, 3, "t2");
    chk("t2 ready during banks", rdy_viol - v0, 0);

    // table-driven readback, base 0x10 count 12, with a 50-cycle stall on word 4
    for (int k = 0; k < 12; k++) rd_mem[16 + k] = tbl[k].din;
    ld_a[0] = 9'h01F; ld_d[0] = rnd_data();
    stall_at = 4; stall_req_n++;
    session(4'h9, 9'h010, 9'd12, 1, 0, "t3");
    for (int k = 0; k < 12 && k < res_q.size(); k++)
      chk($sformatf("t3 tbl%0d", k), res_q[k], tbl[k].exp);
    chk("t4 stall served", stall_ack_n, stall_req_n);
    chk("t4 stable", stable, 1);

    // busy never rises
    busy_never = 1; d0 = done_cnt;
    start_cmd(4'h3, 9'h000, 9'd2); load_words(1, 0);
    seen = 0; rc = 0;
    for (int t = 0; t < 50; t++) begin @(negedge clk); if (core_run) begin seen = 1; rc = cyc; break; end end
    chk("to run", seen, 1);
    seen = 0; early = 0; dc = 0;
    for (int t = 0; t < 1200; t++) begin
      @(negedge clk);
      if (done) begin seen = 1; dc = cyc; break; end
      if (err_timeout) early = 1;
    end
    chk("to done", seen, 1);
    chk("to early err", early, 0);
    chk("to latency", (dc - rc >= BUSY_TO) && (dc - rc <= BUSY_TO + 2), 1);
    chk("to err", err_timeout, 1);
    chk("to no readback", res_valid, 0);
    @(negedge clk);
    chk("to single done", done_cnt - d0, 1);
    chk("to err sticky", err_timeout, 1);
    @(posedge clk); #1; busy_never = 0;
    start_cmd(4'h3, 9'h000, 9'd0);
    @(negedge clk); chk("to err cleared", err_timeout, 0);
    @(posedge clk); #1;
    load_words(1, 0);
    wait_done(200, "to recover done");
    @(posedge clk); #1;

    // reset while core busy (WAIT_LO)
    busy_len = 30; r0 = run_cnt;
    start_cmd(4'h1, 9'h040, 9'd3); load_words(1, 0);
    seen = 0;
    for (int t = 0; t < 60; t++) begin @(negedge clk); if (core_busy) begin seen = 1; break; end end
    chk("rst1 busy seen", seen, 1);
    #2 rst = 1; #1;
    chk("rst1 outs", outs_zero(), 1);
    @(posedge clk); #1; rst = 0; d0 = done_cnt;
    repeat (60) tick();
    chk("rst1 no done", done_cnt - d0, 0);
    chk("rst1 one run", run_cnt - r0, 1);
    busy_len = 5;

    // reset mid-LOAD during bank replay
    r0 = run_cnt;
    start_cmd(4'h1, 9'h000, 9'd0);
    ld_valid = 1; ld_addr = 9'h005; ld_data = rnd_data(); ld_last = 1;
    seen = 0;
    for (int t = 0; t < 10; t++) begin @(negedge clk); if (ld_ready) begin seen = 1; break; end end
    chk("rst2 accept", seen, 1);
    @(posedge clk); #1; ld_valid = 0; ld_last = 0;
    @(negedge clk);
    chk("rst2 in bank replay", core_in_en, 1);
    #2 rst = 1; #1;
    chk("rst2 outs", outs_zero(), 1);
    @(posedge clk); #1; rst = 0;
    repeat (20) tick();
    chk("rst2 no run", run_cnt - r0, 0);
    ld_a[0] = 9'h1F0; ld_a[1] = 9'h0AA; ld_d[0] = rnd_data(); ld_d[1] = rnd_data();
    for (int k = 0; k < 2; k++) rd_mem[(508 + k) % NADDR] = mk(15'($urandom), rnd_data());
    session(4'hC, 9'd508, 9'd2, 2, 1, "rst2 fresh");

    // randomized sessions against the reference model
    rr_rand = 1;
    for (int s = 0; s < 6; s++) begin
      int nw, c, b;
      nw = $urandom_range(1, 6); c = $urandom_range(0, 5); b = $urandom_range(0, NADDR-1);
      busy_dly = $urandom_range(0, 4); busy_len = $urandom_range(1, 6);
      for (int w = 0; w < nw; w++) begin ld_a[w] = ADDR_W'($urandom); ld_d[w] = rnd_data(); end
      for (int k = 0; k < c; k++) rd_mem[(b + k) % NADDR] = mk(15'($urandom), rnd_data());
      session(4'($urandom), ADDR_W'(b), ADDR_W'(c), nw, 2, $sformatf("rnd%0d", s));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running want finished");
    $fatal(1);
  end
endmodule
